// File: rtl/ldpc_cnu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_cnu_pkg
// Brief    : Shared types and default sizes for the min-sum check-node unit.
// Revision : 1.0 - initial release
// ============================================================================
package ldpc_cnu_pkg;

   // Default index width and maximum check-node degree
   localparam int CW_DEF     = 6;
   localparam int DEGREE_DEF = 32;

   // Edge-index scan sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   // Edge index at the default width
   typedef logic [CW_DEF-1:0] index_t;

endpackage
`default_nettype wire

// File: rtl/skip_next_index.sv
`default_nettype none
// ============================================================================
// Module   : skip_next_index
// Brief    : Next edge index with optional single-index skip (+1, or +2 when
//            the +1 value is the skipped index). Result carries one extra bit
//            so callers can see an overflow instead of a silent wrap.
// Revision : 1.0 - initial release
// ============================================================================
module skip_next_index #(
   parameter int CW = 6
) (
   input  logic [CW-1:0] count,
   input  logic          skip_active,
   input  logic [CW-1:0] skip_index,
   output logic [CW:0]   next_index
);

   logic [CW:0] plus_one;

   // Step by one, or by two when landing on the active skip index
   always_comb begin
      plus_one   = {1'b0, count} + (CW+1)'(1);
      next_index = plus_one;
      if (skip_active && (plus_one == {1'b0, skip_index})) begin
         next_index = plus_one + (CW+1)'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/skip_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : skip_scan_counter
// Brief    : Parametrised check-node edge-index sequencer. Scans 0..L with an
//            optional skip of one index, start/busy/done handshake, per-index
//            advance stall and a last-index flag.
// Revision : 1.0 - initial release
// ============================================================================
module skip_scan_counter
   import ldpc_cnu_pkg::*;
#(
   parameter int CW     = CW_DEF,
   parameter int DEGREE = DEGREE_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          skip_en,
   input  logic [CW-1:0] skip_index,
   input  logic [CW-1:0] last_index,
   input  logic          advance,
   output logic [CW-1:0] count,
   output logic          valid,
   output logic          last,
   output logic          busy,
   output logic          done
);

   // Largest legal last index for this instance
   localparam logic [CW:0] MAX_L = (CW+1)'(DEGREE - 1);

   scan_state_t   state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, valid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          skip_active_q, skip_active_d;
   logic [CW-1:0] skip_index_q, skip_index_d;
   logic [CW-1:0] lim_q, lim_d;

   logic [CW-1:0] lim_in;
   logic          skip_act_in;
   logic          first_is_one;
   logic          empty_in;
   logic [CW-1:0] eff_last;
   logic [CW:0]   next_wide;

   // Values derived from the start-time inputs: clamped last index, skip
   // activity, first index and the empty-range case
   always_comb begin
      lim_in       = ({1'b0, last_index} > MAX_L) ? MAX_L[CW-1:0] : last_index;
      skip_act_in  = skip_en && (skip_index <= lim_in);
      first_is_one = skip_act_in && (skip_index == '0);
      empty_in     = first_is_one && (lim_in == '0);
   end

   // Effective final index of the latched scan; the L-1 underflow case is
   // the empty range, which never reaches RUN
   always_comb begin
      eff_last = lim_q;
      if (skip_active_q && (skip_index_q == lim_q)) begin
         eff_last = lim_q - CW'(1);
      end
   end

   skip_next_index #(
      .CW (CW)
   ) u_next (
      .count       (count_q),
      .skip_active (skip_active_q),
      .skip_index  (skip_index_q),
      .next_index  (next_wide)
   );

   // Scan FSM next-state and latch logic
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      valid_d       = valid_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      skip_active_d = skip_active_q;
      skip_index_d  = skip_index_q;
      lim_d         = lim_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               skip_active_d = skip_act_in;
               skip_index_d  = skip_index;
               lim_d         = lim_in;
               if (empty_in) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  count_d = first_is_one ? CW'(1) : '0;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         RUN: begin
            if (advance) begin
               if (count_q == eff_last) begin
                  state_d = DONE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // Saturate rather than wrap if the extra bit ever sets
                  count_d = next_wide[CW] ? '1 : next_wide[CW-1:0];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            count_d = '0;
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         count_q       <= '0;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         skip_active_q <= 1'b0;
         skip_index_q  <= '0;
         lim_q         <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         valid_q       <= valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         skip_active_q <= skip_active_d;
         skip_index_q  <= skip_index_d;
         lim_q         <= lim_d;
      end
   end

   assign count = count_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign last  = valid_q && (count_q == eff_last);

endmodule
`default_nettype wire

// File: tb/tb_skip_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_skip_scan_counter
// Brief    : Scoreboard bench for skip_scan_counter. Two instances (DEGREE 32
//            and 64) share all inputs; expected index sequences are queued
//            from a reference model when a scan is started and popped on
//            each accepted beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skip_scan_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       skip_en;
   logic [5:0] skip_index;
   logic [5:0] last_index;
   logic       advance;

   logic [5:0] count_o [2];
   logic       valid_o [2];
   logic       last_o  [2];
   logic       busy_o  [2];
   logic       done_o  [2];

   int         n_vec = 0;
   int         n_err = 0;
   logic [5:0] exp_q [2][$];
   int         degs [2] = '{32, 64};

   always #5 clk = ~clk;

   skip_scan_counter #(.CW(6), .DEGREE(32)) u_dut32 (
      .clk(clk), .reset(reset), .start(start), .skip_en(skip_en),
      .skip_index(skip_index), .last_index(last_index), .advance(advance),
      .count(count_o[0]), .valid(valid_o[0]), .last(last_o[0]),
      .busy(busy_o[0]), .done(done_o[0])
   );

   skip_scan_counter #(.CW(6), .DEGREE(64)) u_dut64 (
      .clk(clk), .reset(reset), .start(start), .skip_en(skip_en),
      .skip_index(skip_index), .last_index(last_index), .advance(advance),
      .count(count_o[1]), .valid(valid_o[1]), .last(last_o[1]),
      .busy(busy_o[1]), .done(done_o[1])
   );

   // Reference model: queue every index the scan must present, in order
   task automatic build_exp(input int j, input logic se, input int si, input int li);
      int  l;
      bit  act;
      l   = (li > degs[j] - 1) ? degs[j] - 1 : li;
      act = se && (si <= l);
      exp_q[j].delete();
      for (int i = 0; i <= l; i++) begin
         if (!(act && i == si)) exp_q[j].push_back(6'(i));
      end
   endtask

   // Run one scan on both instances; called at a negedge, returns at a
   // negedge with both instances back in IDLE
   task automatic scan(input logic se, input int si, input int li, input bit stall,
                       input bit inject, output int busy0);
      int       first_v [2];
      int       last_acc [2];
      int       done_cyc [2];
      int       done_cnt [2];
      int       busy_cnt [2];
      int       valid_cnt [2];
      int       len [2];
      bit       finished;
      logic     adv_next;
      bit [3:0] pat;
      pat      = 4'b1001;
      finished = 1'b0;
      for (int j = 0; j < 2; j++) begin
         build_exp(j, se, si, li);
         len[j] = exp_q[j].size();
         first_v[j] = -1; last_acc[j] = -1; done_cyc[j] = -1;
         done_cnt[j] = 0; busy_cnt[j] = 0; valid_cnt[j] = 0;
      end
      skip_en    = se;
      skip_index = 6'(si);
      last_index = 6'(li);
      start      = 1'b1;
      advance    = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         adv_next = stall ? pat[k % 4] : 1'b1;
         for (int j = 0; j < 2; j++) begin
            if (valid_o[j]) begin
               valid_cnt[j]++;
               if (first_v[j] < 0) first_v[j] = k;
               n_vec++;
               if (exp_q[j].size() == 0) begin
                  n_err++;
                  $display("FAIL extra_valid[%0d]: count %0d valid, required no valid", j, count_o[j]);
               end else begin
                  n_vec++;
                  if (count_o[j] !== exp_q[j][0]) begin
                     n_err++;
                     $display("FAIL count[%0d] cyc %0d: got %0d, required %0d", j, k, count_o[j], exp_q[j][0]);
                  end
                  n_vec++;
                  if (last_o[j] !== (exp_q[j].size() == 1)) begin
                     n_err++;
                     $display("FAIL last[%0d] cyc %0d: got %b, required %b", j, k, last_o[j], exp_q[j].size() == 1);
                  end
                  if (adv_next) begin
                     void'(exp_q[j].pop_front());
                     last_acc[j] = k;
                  end
               end
            end else begin
               n_vec++;
               if (last_o[j] !== 1'b0) begin
                  n_err++;
                  $display("FAIL last_no_valid[%0d] cyc %0d: got %b, required 0", j, k, last_o[j]);
               end
            end
            if (busy_o[j]) busy_cnt[j]++;
            if (done_o[j]) begin
               done_cnt[j]++;
               done_cyc[j] = k;
            end
            if (done_cyc[j] >= 0 && k == done_cyc[j] + 1) begin
               n_vec++;
               if ({count_o[j], busy_o[j], valid_o[j], done_o[j]} !== 9'b0) begin
                  n_err++;
                  $display("FAIL idle_after_done[%0d]: got count %0d busy %b valid %b done %b, required all 0",
                           j, count_o[j], busy_o[j], valid_o[j], done_o[j]);
               end
            end
         end
         if (done_cyc[0] >= 0 && done_cyc[1] >= 0 && k >= done_cyc[0] + 1 && k >= done_cyc[1] + 1) begin
            finished = 1'b1;
            break;
         end
         start      = inject && (k == 2 || done_o[0]);
         advance    = adv_next;
         skip_en    = 1'($urandom);
         skip_index = 6'($urandom);
         last_index = 6'($urandom);
      end
      start = 1'b0;
      n_vec++;
      if (!finished) begin
         n_err++;
         $display("FAIL scan_timeout: got no completion in 300 cycles, required done on both instances");
      end
      for (int j = 0; j < 2; j++) begin
         n_vec++;
         if (done_cnt[j] !== 1) begin
            n_err++;
            $display("FAIL done_pulses[%0d]: got %0d, required 1", j, done_cnt[j]);
         end
         n_vec++;
         if (exp_q[j].size() !== 0) begin
            n_err++;
            $display("FAIL missing_indices[%0d]: got %0d left, required 0", j, exp_q[j].size());
         end
         if (len[j] > 0) begin
            n_vec++;
            if (first_v[j] !== 0) begin
               n_err++;
               $display("FAIL first_latency[%0d]: got %0d, required 0", j, first_v[j]);
            end
            n_vec++;
            if (done_cyc[j] !== last_acc[j] + 1) begin
               n_err++;
               $display("FAIL done_timing[%0d]: got cyc %0d, required %0d", j, done_cyc[j], last_acc[j] + 1);
            end
         end else begin
            n_vec++;
            if (done_cyc[j] !== 0 || valid_cnt[j] !== 0) begin
               n_err++;
               $display("FAIL empty_range[%0d]: got done cyc %0d valid cycles %0d, required 0 and 0",
                        j, done_cyc[j], valid_cnt[j]);
            end
         end
         n_vec++;
         if (busy_cnt[j] !== valid_cnt[j]) begin
            n_err++;
            $display("FAIL busy_cycles[%0d]: got %0d, required %0d", j, busy_cnt[j], valid_cnt[j]);
         end
         if (!stall) begin
            n_vec++;
            if (valid_cnt[j] !== len[j]) begin
               n_err++;
               $display("FAIL valid_cycles[%0d]: got %0d, required %0d", j, valid_cnt[j], len[j]);
            end
         end
      end
      busy0 = busy_cnt[0];
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; advance = 1'b0;
      skip_en = 1'b0; skip_index = '0; last_index = '0;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 2; j++) begin
         n_vec++;
         if ({count_o[j], valid_o[j], last_o[j], busy_o[j], done_o[j]} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got count %0d valid %b last %b busy %b done %b, required all 0",
                     j, count_o[j], valid_o[j], last_o[j], busy_o[j], done_o[j]);
         end
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_no_skip();
      int b;
      scan(1'b0, 0, 5, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 6) begin
         n_err++;
         $display("FAIL no_skip_busy: got %0d cycles, required 6", b);
      end
   endtask

   task automatic test_mid_skip();
      int b;
      scan(1'b1, 3, 5, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 5) begin
         n_err++;
         $display("FAIL mid_skip_busy: got %0d cycles, required 5", b);
      end
      // Skip index beyond the range leaves the skip inactive
      scan(1'b1, 7, 5, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 6) begin
         n_err++;
         $display("FAIL skip_out_of_range_busy: got %0d cycles, required 6", b);
      end
   endtask

   task automatic test_boundary_skips();
      int b;
      scan(1'b1, 0, 5, 1'b0, 1'b0, b);
      scan(1'b1, 5, 5, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 5) begin
         n_err++;
         $display("FAIL skip_last_busy: got %0d cycles, required 5", b);
      end
   endtask

   task automatic test_stall();
      int b;
      scan(1'b0, 0, 5, 1'b1, 1'b0, b);
      scan(1'b1, 2, 5, 1'b1, 1'b0, b);
   endtask

   task automatic test_empty();
      int b;
      scan(1'b1, 0, 0, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 0) begin
         n_err++;
         $display("FAIL empty_busy: got %0d cycles, required 0", b);
      end
   endtask

   task automatic test_clamp_full();
      int b;
      scan(1'b0, 0, 63, 1'b0, 1'b0, b);
      n_vec++;
      if (b !== 32) begin
         n_err++;
         $display("FAIL clamp_busy: got %0d cycles, required 32", b);
      end
      scan(1'b0, 0, 40, 1'b0, 1'b0, b);
      scan(1'b1, 63, 63, 1'b0, 1'b0, b);
   endtask

   task automatic test_reset_midscan();
      bit found;
      found = 1'b0;
      skip_en = 1'b0; skip_index = '0; last_index = 6'd5;
      start = 1'b1; advance = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (valid_o[0] && count_o[0] == 6'd2) begin
            reset = 1'b1;
            #1;
            found = 1'b1;
            for (int j = 0; j < 2; j++) begin
               n_vec++;
               if ({count_o[j], valid_o[j], last_o[j], busy_o[j], done_o[j]} !== 10'b0) begin
                  n_err++;
                  $display("FAIL async_reset[%0d]: got count %0d valid %b busy %b done %b, required all 0",
                           j, count_o[j], valid_o[j], busy_o[j], done_o[j]);
               end
            end
            break;
         end
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL reset_midscan_reach: got count %0d, required to reach 2", count_o[0]);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         for (int j = 0; j < 2; j++) begin
            n_vec++;
            if ({done_o[j], busy_o[j], valid_o[j]} !== 3'b0) begin
               n_err++;
               $display("FAIL post_reset_idle[%0d]: got done %b busy %b valid %b, required 0",
                        j, done_o[j], busy_o[j], valid_o[j]);
            end
         end
      end
   endtask

   task automatic test_ignored_start();
      int b;
      scan(1'b1, 3, 5, 1'b0, 1'b1, b);
      n_vec++;
      if (b !== 5) begin
         n_err++;
         $display("FAIL ignored_start_busy: got %0d cycles, required 5", b);
      end
      // Any accepted stray start would leave the sequencer busy here
      @(negedge clk);
      n_vec++;
      if (busy_o[0] !== 1'b0 || valid_o[0] !== 1'b0) begin
         n_err++;
         $display("FAIL stray_restart: got busy %b valid %b, required 0", busy_o[0], valid_o[0]);
      end
   endtask

   task automatic test_back_to_back();
      int b;
      scan(1'b0, 0, 2, 1'b0, 1'b0, b);
      scan(1'b1, 1, 3, 1'b0, 1'b0, b);
      scan(1'b1, 0, 0, 1'b0, 1'b0, b);
      scan(1'b0, 0, 1, 1'b1, 1'b0, b);
   endtask

   initial begin
      test_reset();
      test_no_skip();
      test_mid_skip();
      test_boundary_skips();
      test_stall();
      test_empty();
      test_clamp_full();
      test_reset_midscan();
      test_ignored_start();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
